// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one external WIDTH x WIDTH multiplier among N_REQ requesters.
// Optional self-check of the multiplier result: define MULT_SHARE_ARBITER_CHECK_EN.
module mult_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]     rsp_p,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ID_W-1:0]      ptr_r;
  logic [ID_W-1:0]      gid_r;
  logic [ID_W-1:0]      gnt_id_s;
  logic [ID_W-1:0]      ptr_nxt_s;
  logic                 gnt_vld_s;
  logic [N_REQ-1:0]     gnt_oh_s;
  logic [WIDTH-1:0]     op_a_r;
  logic [WIDTH-1:0]     op_b_r;
  logic                 rsp_valid_r;
  logic [ID_W-1:0]      rsp_id_r;
  logic [2*WIDTH-1:0]   rsp_p_r;

  // Round-robin search: first valid requester at or after ptr_r, wrapping.
  always_comb begin
    int  sum_v;
    int  idx_v;
    logic hit_v;
    gnt_vld_s = 1'b0;
    gnt_id_s  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_v     = int'(ptr_r) + k;
      idx_v     = (sum_v >= N_REQ) ? (sum_v - N_REQ) : sum_v;
      hit_v     = !gnt_vld_s && req_valid[idx_v];
      gnt_id_s  = hit_v ? ID_W'(idx_v) : gnt_id_s;
      gnt_vld_s = gnt_vld_s | hit_v;
    end
  end

  assign gnt_oh_s  = gnt_vld_s ? (N_REQ'(1) << gnt_id_s) : '0;
  assign req_ready = (state_r == IDLE) ? gnt_oh_s : '0;
  assign ptr_nxt_s = (gid_r == ID_W'(N_REQ - 1)) ? '0 : (gid_r + ID_W'(1));

  // Next-state logic for the IDLE -> MUL -> RESP cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_vld_s) begin
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch at accept, result capture in MUL, pointer advance on response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r       <= '0;
      gid_r       <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_p_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_vld_s) begin
            op_a_r <= req_a[int'(gnt_id_s)*WIDTH +: WIDTH];
            op_b_r <= req_b[int'(gnt_id_s)*WIDTH +: WIDTH];
            gid_r  <= gnt_id_s;
          end
        end
        MUL: begin
          rsp_p_r     <= mul_p;
          rsp_id_r    <= gid_r;
          rsp_valid_r <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            ptr_r       <= ptr_nxt_s;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign mul_a     = op_a_r;
  assign mul_b     = op_b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_p     = rsp_p_r;

`ifdef MULT_SHARE_ARBITER_CHECK_EN
  logic err_r;

  function automatic logic [2*WIDTH-1:0] mul_ref(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return {WIDTH'(0), a} * {WIDTH'(0), b};
  endfunction

  // Sticky flag when the external product disagrees with the local reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == MUL) && (mul_p != mul_ref(op_a_r, op_b_r))) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized/directed bench for mult_share_arbiter against a transaction-level model.
module tb_mult_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_p;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_p;
  logic           err;
  logic           corrupt = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m       = 0;
  logic err_m     = 1'b0;

  mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .err(err)
  );

  // External multiplier, with a fault-injection override.
  assign mul_p = corrupt ? 8'h00 : ({4'h0, mul_a} * {4'h0, mul_b});

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int slot, input logic [W-1:0] x);
    logic [N*W-1:0] v;
    v = '0;
    v[slot*W +: W] = x;
    return v;
  endfunction

  // One full request/response exchange; entered and left at an IDLE negedge.
  task automatic do_txn(input logic [N-1:0] v, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input int stall);
    int g;
    int ea;
    int eb;
    int ep;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    end
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
    if (g < 0) begin
      check("idle_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      check("idle_no_rsp", 32'(rsp_valid), 32'h0);
      return;
    end
    check("grant", 32'(req_ready), 32'(1) << g);
    ea = int'(a[g*W +: W]);
    eb = int'(b[g*W +: W]);
    ep = corrupt ? 0 : ea * eb;
    @(negedge clk);
    check("mul_a", 32'(mul_a), 32'(ea));
    check("mul_b", 32'(mul_b), 32'(eb));
    check("ready_in_mul", 32'(req_ready), 32'h0);
    check("valid_in_mul", 32'(rsp_valid), 32'h0);
    if (corrupt && (ea * eb) != 0) err_m = 1'b1;
    req_valid = N'($urandom);
    req_a     = (N*W)'($urandom);
    req_b     = (N*W)'($urandom);
    rsp_ready = (stall == 0);
    @(negedge clk);
    corrupt = 1'b0;
    check("rsp_valid", 32'(rsp_valid), 32'h1);
    check("rsp_id", 32'(rsp_id), 32'(g));
    check("rsp_p", 32'(rsp_p), 32'(ep));
    check("err", 32'(err), 32'(err_m));
    check("ready_in_resp", 32'(req_ready), 32'h0);
    check("mul_a_hold", 32'(mul_a), 32'(ea));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'h1);
      check("stall_id", 32'(rsp_id), 32'(g));
      check("stall_p", 32'(rsp_p), 32'(ep));
      check("stall_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid), 32'h0);
    ptr_m = (g + 1) % N;
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    check("rst_p", 32'(rsp_p), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_mul_a", 32'(mul_a), 32'h0);
    rst = 1'b0;

    // Single request, then the value corners on successive requesters.
    do_txn(4'b0001, pack(0, 4'd3), pack(0, 4'd3), 0);
    do_txn(4'b0010, pack(1, 4'd7), pack(1, 4'd1), 0);
    do_txn(4'b0100, pack(2, 4'd10), pack(2, 4'd10), 0);
    do_txn(4'b1000, pack(3, 4'd15), pack(3, 4'd15), 0);
    do_txn(4'b0000, '0, '0, 0);

    // All requesters valid: rotation 0,1,2,3,0 at one result per 3 cycles.
    for (int i = 0; i < 5; i++) do_txn(4'hF, 16'($urandom), 16'($urandom), 0);

    // Backpressure for 5 cycles.
    do_txn(4'hF, 16'($urandom), 16'($urandom), 5);

    // Reset during MUL discards the transaction and clears the pointer.
    req_valid = 4'b0010;
    req_a     = pack(1, 4'd5);
    req_b     = pack(1, 4'd6);
    #1;
    check("t5_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    check("t5_mul_a", 32'(mul_a), 32'h5);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 32'h0);
    check("t5_rst_p", 32'(rsp_p), 32'h0);
    check("t5_rst_id", 32'(rsp_id), 32'h0);
    check("t5_rst_mul_b", 32'(mul_b), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("t5_no_rsp", 32'(seen), 32'h0);
    ptr_m = 0;
    err_m = 1'b0;
    do_txn(4'hF, 16'($urandom), 16'($urandom), 1);

`ifdef MULT_SHARE_ARBITER_CHECK_EN
    corrupt = 1'b1;
    do_txn(4'b0010, pack(1, 4'd2), pack(1, 4'd3), 0);
    do_txn(4'b0100, pack(2, 4'd4), pack(2, 4'd4), 0);
`endif

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      do_txn(4'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
